nn_infer_ctrl: RTL and testbench

NN_INFER_CTRL -- requirements
Module: nn_infer_ctrl

---
 rtl/nn_infer_ctrl.sv | 129 ++++++++++++
 tb/tb_nn_infer_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_infer_ctrl.sv
// nn_infer_ctrl: loads a pixel frame into a flat buffer, fires the network once, holds its result for a consumer.
// Optional NN_TIMEOUT_EN adds a WAIT watchdog that returns a timeout marker (resTimeout=1, resIndex=4'hF).
module nn_infer_ctrl #(
    parameter int numInputs     = 784,
    parameter int dataWidth     = 16,
    parameter int timeoutCycles = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pixValid,
    input  logic [dataWidth-1:0]           pixData,
    output logic                           pixReady,
    output logic [dataWidth*numInputs-1:0] NNin,
    output logic                           NNvalid,
    input  logic                           maxValid,
    input  logic [3:0]                     maxIndex,
    input  logic [dataWidth-1:0]           maxValue,
    output logic                           resValid,
    input  logic                           resReady,
    output logic [3:0]                     resIndex,
    output logic [dataWidth-1:0]           resValue,
    output logic                           resTimeout,
    output logic                           busy,
    output logic [2:0]                     dbgState
);

    // Handshakes: a pixel moves when pixValid && pixReady at a rising edge; a result moves when
    // resValid && resReady. Neither ready depends combinationally on its valid, and a raised valid
    // (resValid) holds its payload unchanged until the transfer completes.

    localparam int CW = (numInputs > 1) ? $clog2(numInputs) : 1;

    if (numInputs < 2 || timeoutCycles < 2) begin : g_bad_params
        $error("nn_infer_ctrl: numInputs and timeoutCycles must both be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FIRE = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   pixCnt;

`ifdef NN_TIMEOUT_EN
    localparam int TW = $clog2(timeoutCycles);
    logic [TW-1:0]   waitCnt;
`endif

    assign dbgState = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pixCnt     <= '0;
            NNin       <= '0;
            NNvalid    <= 1'b0;
            pixReady   <= 1'b1;
            resValid   <= 1'b0;
            resIndex   <= 4'd0;
            resValue   <= '0;
            resTimeout <= 1'b0;
            busy       <= 1'b0;
`ifdef NN_TIMEOUT_EN
            waitCnt    <= '0;
`endif
        end else begin
            NNvalid <= 1'b0;
            case (state)
                // pixCnt is always 0 in IDLE, so the first pixel lands in slot 0
                IDLE, LOAD: begin
                    if (pixValid) begin
                        NNin[int'(pixCnt)*dataWidth +: dataWidth] <= pixData;
                        busy <= 1'b1;
                        if (pixCnt == CW'(numInputs - 1)) begin
                            pixCnt   <= '0;
                            pixReady <= 1'b0;
                            NNvalid  <= 1'b1;
                            state    <= FIRE;
                        end else begin
                            pixCnt <= pixCnt + CW'(1);
                            state  <= LOAD;
                        end
                    end
                end
                FIRE: begin
                    state <= WAIT;
`ifdef NN_TIMEOUT_EN
                    waitCnt <= '0;
`endif
                end
                WAIT: begin
                    // a real result wins over a watchdog expiry in the same cycle
                    if (maxValid) begin
                        resIndex   <= maxIndex;
                        resValue   <= maxValue;
                        resTimeout <= 1'b0;
                        resValid   <= 1'b1;
                        state      <= DONE;
                    end
`ifdef NN_TIMEOUT_EN
                    else if (waitCnt == TW'(timeoutCycles - 1)) begin
                        resIndex   <= 4'hF;
                        resValue   <= '0;
                        resTimeout <= 1'b1;
                        resValid   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        waitCnt <= waitCnt + TW'(1);
                    end
`endif
                end
                DONE: begin
                    if (resReady) begin
                        resValid <= 1'b0;
                        pixReady <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// Randomised frame/result traffic for nn_infer_ctrl with a queue-based scoreboard and independent monitor.
// Build with NN_TIMEOUT_EN defined to also exercise the WAIT watchdog (timeoutCycles=16).
module tb_nn_infer_ctrl;

    localparam int N  = 784;
    localparam int DW = 16;
    localparam int TO = 16;
    localparam int W  = N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pixValid = 1'b0;
    logic [DW-1:0] pixData = '0;
    logic          pixReady;
    logic [W-1:0]  NNin;
    logic          NNvalid;
    logic          maxValid = 1'b0;
    logic [3:0]    maxIndex = '0;
    logic [DW-1:0] maxValue = '0;
    logic          resValid;
    logic          resReady = 1'b0;
    logic [3:0]    resIndex;
    logic [DW-1:0] resValue;
    logic          resTimeout;
    logic          busy;
    logic [2:0]    dbgState;

    nn_infer_ctrl #(
        .numInputs    (N),
        .dataWidth    (DW),
        .timeoutCycles(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pixValid  (pixValid),
        .pixData   (pixData),
        .pixReady  (pixReady),
        .NNin      (NNin),
        .NNvalid   (NNvalid),
        .maxValid  (maxValid),
        .maxIndex  (maxIndex),
        .maxValue  (maxValue),
        .resValid  (resValid),
        .resReady  (resReady),
        .resIndex  (resIndex),
        .resValue  (resValue),
        .resTimeout(resTimeout),
        .busy      (busy),
        .dbgState  (dbgState)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    // ---------------- scoreboard state ----------------
    logic [W-1:0]    exp_q[$];
    logic [DW+4:0]   res_q[$];
    logic [W-1:0]    cur_frame = '0;
    logic [DW-1:0]   pix_model [N];
    int              total = 0;
    int              bad = 0;
    int              expect_fire_cycle = -1;
    int              expect_res_cycle = -1;
    int              fire_cyc = 0;
    bit              in_flight = 1'b0;
    bit              in_reset = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_frame(input string name, input logic [W-1:0] exp);
        int bk = 0;
        for (int k = N - 1; k >= 0; k--)
            if (NNin[k*DW +: DW] !== exp[k*DW +: DW]) bk = k;
        check($sformatf("%s slot %0d", name, bk), 32'(NNin[bk*DW +: DW]), 32'(exp[bk*DW +: DW]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input int hold);
        in_reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pixValid = 1'b0;
        maxValid = 1'b0;
        resReady = 1'b0;
        #2;
        check("rst_nnvalid",    32'(NNvalid),    32'd0);
        check("rst_resvalid",   32'(resValid),   32'd0);
        check("rst_resindex",   32'(resIndex),   32'd0);
        check("rst_resvalue",   32'(resValue),   32'd0);
        check("rst_restimeout", 32'(resTimeout), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_nnin_zero",  32'(|NNin),      32'd0);
        repeat (hold) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        res_q.delete();
        expect_fire_cycle = -1;
        expect_res_cycle  = -1;
        in_flight = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_pixready", 32'(pixReady), 32'd1);
        check("post_rst_busy",     32'(busy),     32'd0);
        in_reset = 1'b0;
    endtask

    task automatic idle_noise();
        @(negedge clk);
        maxValid = 1'b1;
        maxIndex = 4'($urandom);
        maxValue = DW'($urandom);
        @(negedge clk);
        maxValid = 1'b0;
        @(negedge clk);
        check("idle_maxvalid_ignored", 32'(resValid), 32'd0);
        check("idle_maxvalid_busy",    32'(busy),     32'd0);
    endtask

    // Streams npix pixels; with gaps, every third cycle carries no pixel.
    task automatic send_frame(input int npix, input bit gaps);
        int k = 0;
        int c = 0;
        logic [W-1:0] f;
        while (k < npix) begin
            @(negedge clk);
            maxValid = (c == 150);
            maxIndex = 4'($urandom);
            maxValue = DW'($urandom);
            pixData  = DW'($urandom);
            if (gaps && (c % 3 == 2)) begin
                pixValid = 1'b0;
            end else begin
                pixValid = 1'b1;
                pix_model[k] = pixData;
                k++;
            end
            c++;
        end
        if (npix == N) begin
            f = '0;
            for (int j = 0; j < N; j++) f[j*DW +: DW] = pix_model[j];
            exp_q.push_back(f);
            expect_fire_cycle = cycle + 1;
            fire_cyc = cycle + 1;
        end
    endtask

    // Presents maxValid on the d-th WAIT cycle (give=0: never), then consumes the result after hold stalls.
    task automatic do_result(input int d, input bit give, input int hold,
                             input logic [3:0] idx, input logic [DW-1:0] val);
        bit hit;
        int target;
        int n;
        hit = give;
`ifdef NN_TIMEOUT_EN
        if (d > TO) hit = 1'b0;
        if (hit) begin
            res_q.push_back({1'b0, idx, val});
            target = fire_cyc + d + 1;
        end else begin
            res_q.push_back({1'b1, 4'hF, DW'(0)});
            target = fire_cyc + TO + 1;
        end
`else
        res_q.push_back({1'b0, idx, val});
        target = fire_cyc + d + 1;
`endif
        expect_res_cycle = target;
        while (cycle < fire_cyc + d) begin
            @(negedge clk);
            pixValid = 1'b1;
            pixData  = DW'($urandom);
            maxValid = 1'b0;
        end
        maxValid = give;
        maxIndex = idx;
        maxValue = val;
        @(negedge clk);
        maxValid = 1'b0;
        maxIndex = 4'($urandom);
        maxValue = DW'($urandom);
        while (cycle < target + hold) begin
            @(negedge clk);
            pixData = DW'($urandom);
        end
        n = 0;
        while (!resValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!resValid) begin
            check("res_wait_bound", 32'(resValid), 32'd1);
            apply_reset(2);
            return;
        end
        resReady = 1'b1;
        @(negedge clk);
        resReady = 1'b0;
        pixValid = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit            prev_valid = 1'b0;
        bit            prev_hold = 1'b0;
        logic [DW+4:0] prev_res = '0;
        int            fire_seen = -10;
        int            idle_chk = -1;
        forever begin
            @(negedge clk);
            #2;
            if (in_reset) begin
                prev_valid = 1'b0;
                prev_hold  = 1'b0;
                fire_seen  = -10;
                idle_chk   = -1;
                in_flight  = 1'b0;
                continue;
            end
            if (cycle == fire_seen + 1) begin
                check("nnvalid_pulse_width", 32'(NNvalid), 32'd0);
            end else if (NNvalid) begin
                if (exp_q.size() == 0) begin
                    check("nnvalid_unexpected", 32'(NNvalid), 32'd0);
                end else begin
                    check("nnvalid_latency", cycle, expect_fire_cycle);
                    cur_frame = exp_q.pop_front();
                    check_frame("nnin_frame", cur_frame);
                    expect_fire_cycle = -1;
                    in_flight = 1'b1;
                    fire_seen = cycle;
                end
            end else if (expect_fire_cycle >= 0 && cycle >= expect_fire_cycle) begin
                check("nnvalid_missing", 32'(NNvalid), 32'd1);
                expect_fire_cycle = -1;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end

            check("pixready", 32'(pixReady), 32'(!in_flight));
            if (in_flight) begin
                check("busy_inflight", 32'(busy), 32'd1);
                if (cycle != fire_seen) check_frame("nnin_hold", cur_frame);
            end

            if (resValid && !prev_valid) begin
                if (expect_res_cycle < 0) begin
                    check("resvalid_unexpected", 32'(resValid), 32'd0);
                end else begin
                    check("resvalid_latency", cycle, expect_res_cycle);
                    expect_res_cycle = -1;
                end
            end else if (!resValid && expect_res_cycle >= 0 && cycle >= expect_res_cycle) begin
                check("resvalid_missing", 32'(resValid), 32'd1);
                expect_res_cycle = -1;
            end
            if (prev_hold) begin
                check("res_hold_valid", 32'(resValid), 32'd1);
                check("res_hold_data", 32'({resTimeout, resIndex, resValue}), 32'(prev_res));
            end
            if (cycle == idle_chk) begin
                check("idle_busy",     32'(busy),     32'd0);
                check("idle_resvalid", 32'(resValid), 32'd0);
            end
            if (resValid && resReady) begin
                if (res_q.size() == 0) begin
                    check("res_unexpected", 32'(resValid), 32'd0);
                end else begin
                    check("res_data", 32'({resTimeout, resIndex, resValue}), 32'(res_q.pop_front()));
                end
                in_flight = 1'b0;
                idle_chk = cycle + 1;
            end
            prev_valid = resValid;
            prev_hold  = resValid && !resReady;
            prev_res   = {resTimeout, resIndex, resValue};
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        apply_reset(2);
        idle_noise();

        // known result, consumer stalls for 10 cycles
        send_frame(N, 1'b0);
        do_result(3, 1'b1, 10, 4'd7, 16'h0A80);

        // partial frame discarded by reset, then a clean frame
        send_frame(300, 1'b0);
        apply_reset(2);
        send_frame(N, 1'b0);
        do_result($urandom_range(1, 12), 1'b1, $urandom_range(0, 5), 4'($urandom), DW'($urandom));

        // gapped stream
        send_frame(N, 1'b1);
        do_result($urandom_range(1, 12), 1'b1, $urandom_range(0, 5), 4'($urandom), DW'($urandom));

        for (int i = 0; i < 3; i++) begin
            send_frame(N, 1'($urandom_range(0, 1)));
            do_result($urandom_range(1, 12), 1'b1, $urandom_range(0, 6), 4'($urandom), DW'($urandom));
        end

        // reset while waiting on the network
        send_frame(N, 1'b0);
        repeat (4) @(negedge clk);
        apply_reset(1);
        idle_noise();
        send_frame(N, 1'b1);
        do_result($urandom_range(1, 12), 1'b1, $urandom_range(0, 5), 4'($urandom), DW'($urandom));

`ifdef NN_TIMEOUT_EN
        send_frame(N, 1'b0);
        do_result(1, 1'b0, 2, 4'd0, DW'(0));
        send_frame(N, 1'b0);
        do_result(TO, 1'b1, 0, 4'd3, DW'($urandom));
        send_frame(N, 1'b0);
        do_result(TO + 1, 1'b1, 1, 4'($urandom), DW'($urandom));
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size() + res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
